// File: rtl/cpu_control_if.sv
// cpu_control_if: memory request/response handshake between the control FSM and memory
interface cpu_control_if;
  logic mem_read;
  logic mem_write;
  logic [1:0] mem_byte_enable;
  logic mem_resp;
  modport master(output mem_read, mem_write, mem_byte_enable, input mem_resp);
  modport slave(input mem_read, mem_write, mem_byte_enable, output mem_resp);
endinterface

// File: rtl/cpu_control.sv
// cpu_control: LC-3b multicycle control FSM with memory-wait timeout and sticky error state
module cpu_control #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [3:0] opcode,
  input  logic ir5,
  input  logic branch_enable,
  cpu_control_if.master mem,
  output logic load_pc,
  output logic load_ir,
  output logic load_regfile,
  output logic load_mar,
  output logic load_mdr,
  output logic load_cc,
  output logic pcmux_sel,
  output logic storemux_sel,
  output logic alumux_sel,
  output logic regfilemux_sel,
  output logic marmux_sel,
  output logic mdrmux_sel,
  output logic sr2mux_sel,
  output logic addr1mux_sel,
  output logic addr2mux_sel,
  output logic leamux_sel,
  output logic [2:0] aluop,
  output logic error,
  output logic jmpmux_sel,
  output logic trapaddrmux_sel,
  output logic trappcmux_sel,
  output logic trapvecmux_sel,
  output logic trapdestmux_sel,
  output logic sextmux_sel,
  output logic zextmux_sel,
  output logic byte_enable_mux_sel,
  output logic splitdatamux_sel,
  output logic mdrmarmux_sel
);
  localparam logic [3:0] OP_BR = 4'h0, OP_ADD = 4'h1, OP_AND = 4'h5, OP_LDR = 4'h6;
  localparam logic [3:0] OP_STR = 4'h7, OP_NOT = 4'h9, OP_JMP = 4'hc, OP_LEA = 4'he;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_AND = 3'd1, ALU_NOT = 3'd2, ALU_PASS = 3'd3;
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [3:0] {
    FETCH1, FETCH2, FETCH3, DECODE, ADD, AND, NOT, BR,
    JMP, LEA, CALC_ADDR, LDR1, LDR2, STR1, STR2, ERROR
  } state_t;
  state_t state, next;
  logic [CW-1:0] wait_cnt;
  logic in_wait, timeout;
  assign in_wait = state inside {FETCH2, LDR1, STR2};
  assign timeout = in_wait && !mem.mem_resp && wait_cnt == CW'(MEM_TIMEOUT - 1);
  assign mem.mem_byte_enable = {2{mem.mem_write}};
  assign {jmpmux_sel, trapaddrmux_sel, trappcmux_sel, trapvecmux_sel, trapdestmux_sel} = 5'b0;
  assign {sextmux_sel, zextmux_sel, byte_enable_mux_sel, splitdatamux_sel, mdrmarmux_sel} = 5'b0;
  always_comb begin
    next = state;
    case (state)
      FETCH1: next = FETCH2;
      FETCH2: next = mem.mem_resp ? FETCH3 : timeout ? ERROR : FETCH2;
      FETCH3: next = DECODE;
      DECODE:
        case (opcode)
          OP_ADD: next = ADD;
          OP_AND: next = AND;
          OP_NOT: next = NOT;
          OP_BR: next = BR;
          OP_JMP: next = JMP;
          OP_LEA: next = LEA;
          OP_LDR, OP_STR: next = CALC_ADDR;
          default: next = ERROR;
        endcase
      ADD, AND, NOT, BR, JMP, LEA, LDR2: next = FETCH1;
      CALC_ADDR: next = opcode == OP_LDR ? LDR1 : STR1;
      LDR1: next = mem.mem_resp ? LDR2 : timeout ? ERROR : LDR1;
      STR1: next = STR2;
      STR2: next = mem.mem_resp ? FETCH1 : timeout ? ERROR : STR2;
      default: next = ERROR;
    endcase
  end
  // Leaving a wait state (or never entering one) zeroes the counter, so entry always starts at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH1;
      wait_cnt <= '0;
    end else begin
      state <= next;
      wait_cnt <= (in_wait && !mem.mem_resp) ? wait_cnt + 1'b1 : '0;
    end
  end
  // Reset forces FETCH1 asynchronously; gating FETCH1's strobes with rst_n keeps every output low in reset
  always_comb begin
    mem.mem_read = 1'b0;
    mem.mem_write = 1'b0;
    {load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc} = 6'b0;
    {pcmux_sel, storemux_sel, alumux_sel, regfilemux_sel, marmux_sel} = 5'b0;
    {mdrmux_sel, sr2mux_sel, addr1mux_sel, addr2mux_sel, leamux_sel} = 5'b0;
    aluop = ALU_ADD;
    error = 1'b0;
    case (state)
      FETCH1: {marmux_sel, load_mar, load_pc} = {3{rst_n}};
      FETCH2, LDR1: {mem.mem_read, mdrmux_sel, load_mdr} = {1'b1, 1'b1, mem.mem_resp};
      FETCH3: load_ir = 1'b1;
      DECODE: ;
      ADD, AND: begin
        sr2mux_sel = ir5;
        aluop = state == AND ? ALU_AND : ALU_ADD;
        {load_regfile, load_cc} = 2'b11;
      end
      NOT: begin
        aluop = ALU_NOT;
        {load_regfile, load_cc} = 2'b11;
      end
      BR: {pcmux_sel, load_pc} = {1'b1, branch_enable};
      JMP: {addr1mux_sel, addr2mux_sel, pcmux_sel, load_pc} = 4'b1111;
      LEA: {leamux_sel, load_regfile, load_cc} = 3'b111;
      CALC_ADDR: {alumux_sel, load_mar} = 2'b11;
      LDR2: {regfilemux_sel, load_regfile, load_cc} = 3'b111;
      STR1: begin
        storemux_sel = 1'b1;
        aluop = ALU_PASS;
        load_mdr = 1'b1;
      end
      STR2: mem.mem_write = 1'b1;
      default: error = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_cpu_control.sv
// tb_cpu_control: cycle-by-cycle scoreboard check of cpu_control outputs against expected state vectors
module tb_cpu_control;
  localparam logic [3:0] OP_BR = 4'h0, OP_ADD = 4'h1, OP_AND = 4'h5, OP_LDR = 4'h6;
  localparam logic [3:0] OP_STR = 4'h7, OP_NOT = 4'h9, OP_JMP = 4'hc, OP_LEA = 4'he, OP_TRAP = 4'hf;
  localparam int RST = 0, F1 = 1, F2 = 2, F3 = 3, DEC = 4, SADD = 5, SAND = 6, SNOT = 7, SBR = 8;
  localparam int SJMP = 9, SLEA = 10, CALC = 11, LDR1 = 12, LDR2 = 13, STR1 = 14, STR2 = 15, ERR = 16;
  string names[17] = '{"rst", "fetch1", "fetch2", "fetch3", "decode", "add", "and", "not", "br",
                       "jmp", "lea", "calc_addr", "ldr1", "ldr2", "str1", "str2", "error"};
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] opcode;
  logic ir5, branch_enable;
  logic load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc;
  logic pcmux_sel, storemux_sel, alumux_sel, regfilemux_sel, marmux_sel;
  logic mdrmux_sel, sr2mux_sel, addr1mux_sel, addr2mux_sel, leamux_sel;
  logic [2:0] aluop;
  logic error;
  logic jmpmux_sel, trapaddrmux_sel, trappcmux_sel, trapvecmux_sel, trapdestmux_sel;
  logic sextmux_sel, zextmux_sel, byte_enable_mux_sel, splitdatamux_sel, mdrmarmux_sel;
  logic [24:0] got;
  logic [24:0] sb[$];
  int checks = 0;
  int errs = 0;
  cpu_control_if bus();
  cpu_control #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .ir5(ir5), .branch_enable(branch_enable),
    .mem(bus),
    .load_pc(load_pc), .load_ir(load_ir), .load_regfile(load_regfile), .load_mar(load_mar),
    .load_mdr(load_mdr), .load_cc(load_cc),
    .pcmux_sel(pcmux_sel), .storemux_sel(storemux_sel), .alumux_sel(alumux_sel),
    .regfilemux_sel(regfilemux_sel), .marmux_sel(marmux_sel), .mdrmux_sel(mdrmux_sel),
    .sr2mux_sel(sr2mux_sel), .addr1mux_sel(addr1mux_sel), .addr2mux_sel(addr2mux_sel),
    .leamux_sel(leamux_sel), .aluop(aluop), .error(error),
    .jmpmux_sel(jmpmux_sel), .trapaddrmux_sel(trapaddrmux_sel), .trappcmux_sel(trappcmux_sel),
    .trapvecmux_sel(trapvecmux_sel), .trapdestmux_sel(trapdestmux_sel), .sextmux_sel(sextmux_sel),
    .zextmux_sel(zextmux_sel), .byte_enable_mux_sel(byte_enable_mux_sel),
    .splitdatamux_sel(splitdatamux_sel), .mdrmarmux_sel(mdrmarmux_sel)
  );
  always #5 clk = ~clk;
  assign got = {bus.mem_read, bus.mem_write, bus.mem_byte_enable, load_pc, load_ir, load_regfile,
                load_mar, load_mdr, load_cc, pcmux_sel, storemux_sel, alumux_sel, regfilemux_sel,
                marmux_sel, mdrmux_sel, sr2mux_sel, addr1mux_sel, addr2mux_sel, leamux_sel, aluop,
                error, |{jmpmux_sel, trapaddrmux_sel, trappcmux_sel, trapvecmux_sel, trapdestmux_sel,
                         sextmux_sel, zextmux_sel, byte_enable_mux_sel, splitdatamux_sel, mdrmarmux_sel}};
  function automatic logic [24:0] expv(input int st, input logic i5, input logic be, input logic resp);
    logic rd, wr, lpc, lir, lrf, lmar, lmdr, lcc, pcm, stm, alm, rfm, marm, mdrm, sr2, a1, a2, lea, err;
    logic [2:0] alu;
    {rd, wr, lpc, lir, lrf, lmar, lmdr, lcc, pcm, stm, alm, rfm, marm, mdrm, sr2, a1, a2, lea, err} = 19'b0;
    alu = 3'd0;
    case (st)
      F1: {marm, lmar, lpc} = 3'b111;
      F2, LDR1: {rd, mdrm, lmdr} = {1'b1, 1'b1, resp};
      F3: lir = 1'b1;
      SADD: {sr2, lrf, lcc} = {i5, 2'b11};
      SAND: begin {sr2, lrf, lcc} = {i5, 2'b11}; alu = 3'd1; end
      SNOT: begin {lrf, lcc} = 2'b11; alu = 3'd2; end
      SBR: {pcm, lpc} = {1'b1, be};
      SJMP: {a1, a2, pcm, lpc} = 4'b1111;
      SLEA: {lea, lrf, lcc} = 3'b111;
      CALC: {alm, lmar} = 2'b11;
      LDR2: {rfm, lrf, lcc} = 3'b111;
      STR1: begin {stm, lmdr} = 2'b11; alu = 3'd3; end
      STR2: wr = 1'b1;
      ERR: err = 1'b1;
      default: ;
    endcase
    return {rd, wr, {2{wr}}, lpc, lir, lrf, lmar, lmdr, lcc, pcm, stm, alm, rfm, marm, mdrm,
            sr2, a1, a2, lea, alu, err, 1'b0};
  endfunction
  task automatic check(input string tag, input logic [24:0] obs, input logic [24:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask
  // One clock: drive inputs just after the rising edge, compare at the falling edge
  task automatic cyc(input int st, input logic [3:0] op, input logic resp = 1'b0,
                     input logic i5 = 1'b0, input logic be = 1'b0);
    rst_n = (st != RST);
    opcode = op;
    ir5 = i5;
    branch_enable = be;
    bus.mem_resp = resp;
    sb.push_back(expv(st, i5, be, resp));
    @(negedge clk);
    check(names[st], got, sb.pop_front());
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input logic [3:0] op, input int waits);
    cyc(F1, op);
    repeat (waits) cyc(F2, op, 1'b0);
    cyc(F2, op, 1'b1);
    cyc(F3, op);
    cyc(DEC, op);
  endtask
  initial begin
    rst_n = 1'b0;
    opcode = 4'h0;
    ir5 = 1'b0;
    branch_enable = 1'b0;
    bus.mem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc(RST, OP_ADD);
    cyc(RST, OP_ADD, 1'b1);
    fetch(OP_ADD, 0);
    cyc(SADD, OP_ADD, 1'b0, 1'b1);
    fetch(OP_AND, 1);
    cyc(SAND, OP_AND, 1'b0, 1'b0);
    fetch(OP_NOT, 0);
    cyc(SNOT, OP_NOT, 1'b0, 1'b1);
    fetch(OP_BR, 0);
    cyc(SBR, OP_BR, 1'b0, 1'b0, 1'b0);
    fetch(OP_BR, 0);
    cyc(SBR, OP_BR, 1'b0, 1'b0, 1'b1);
    fetch(OP_JMP, 0);
    cyc(SJMP, OP_JMP);
    fetch(OP_LEA, 0);
    cyc(SLEA, OP_LEA);
    fetch(OP_LDR, 0);
    cyc(CALC, OP_LDR);
    cyc(LDR1, OP_LDR, 1'b0);
    cyc(LDR1, OP_LDR, 1'b1);
    cyc(LDR2, OP_LDR);
    fetch(OP_STR, 2);
    cyc(CALC, OP_STR);
    cyc(STR1, OP_STR);
    repeat (3) cyc(STR2, OP_STR, 1'b0);
    cyc(STR2, OP_STR, 1'b1);
    fetch(OP_ADD, 3);
    cyc(SADD, OP_ADD, 1'b0, 1'b0);
    fetch(OP_LDR, 3);
    cyc(CALC, OP_LDR);
    repeat (4) cyc(LDR1, OP_LDR, 1'b0);
    cyc(ERR, OP_LDR);
    cyc(ERR, OP_LDR, 1'b1);
    cyc(RST, OP_ADD);
    cyc(F1, OP_ADD);
    repeat (4) cyc(F2, OP_ADD, 1'b0);
    cyc(ERR, OP_ADD);
    cyc(ERR, OP_ADD, 1'b1);
    cyc(RST, OP_ADD);
    fetch(OP_TRAP, 0);
    cyc(ERR, OP_TRAP);
    cyc(ERR, OP_TRAP, 1'b1);
    cyc(RST, OP_TRAP);
    fetch(OP_JMP, 0);
    cyc(SJMP, OP_JMP);
    fetch(OP_STR, 0);
    cyc(CALC, OP_STR);
    cyc(STR1, OP_STR);
    cyc(STR2, OP_STR, 1'b0);
    cyc(RST, OP_STR);
    cyc(F1, OP_STR);
    cyc(F2, OP_STR, 1'b1);
    cyc(F3, OP_STR);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/cpu_control.md
CPU_CONTROL -- requirements
Module: cpu_control

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255: consecutive memory-wait cycles without mem_resp before the block enters ERROR.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port opcode, input, lc3b_opcode (4): current IR opcode.
REQ-005 SHALL have port ir5, input, 1: IR[5], the immediate flag.
REQ-006 SHALL have port branch_enable, input, 1: NZP match from the datapath.
REQ-007 SHALL have port mem_resp, input, 1: memory transfer complete.
REQ-008 SHALL have port mem_read, output, 1: memory read request.
REQ-009 SHALL have port mem_write, output, 1: memory write request.
REQ-010 SHALL have port mem_byte_enable, output, 2: byte lanes; 2'b11 whenever mem_write=1, else 2'b00.
REQ-011 SHALL have ports load_pc, load_ir, load_regfile, load_mar, load_mdr and load_cc, each output, 1: datapath register load strobes.
REQ-012 SHALL have ports pcmux_sel, storemux_sel, alumux_sel, regfilemux_sel, marmux_sel, mdrmux_sel, sr2mux_sel, addr1mux_sel, addr2mux_sel and leamux_sel, each output, 1: datapath mux selects.
REQ-013 SHALL have port aluop, output, lc3b_aluop: ALU operation; alu_add when not otherwise specified.
REQ-014 SHALL have port error, output, 1: sticky fault flag, high in ERROR.
REQ-015 The top level SHALL tie the datapath selects for jmpmux, trapaddrmux, trappcmux, trapvecmux, trapdestmux, sextmux, zextmux, byte_enable_mux, splitdatamux and mdrmarmux to 0.

Function
REQ-016 SHALL be a Moore FSM with states FETCH1, FETCH2, FETCH3, DECODE, ADD, AND, NOT, BR, JMP, LEA, CALC_ADDR, LDR1, LDR2, STR1, STR2 and ERROR; every output not listed for a state SHALL be 0, with aluop at alu_add.
REQ-017 FETCH1: marmux_sel=1, load_mar=1, pcmux_sel=0, load_pc=1; next state FETCH2.
REQ-018 FETCH2: mem_read=1, mdrmux_sel=1, load_mdr=mem_resp; the state SHALL remain FETCH2 until mem_resp=1, then go to FETCH3.
REQ-019 FETCH3: load_ir=1; next state DECODE.
REQ-020 DECODE SHALL dispatch on opcode: ADD to ADD, AND to AND, NOT to NOT, BR to BR, JMP to JMP, LEA to LEA, and LDR or STR to CALC_ADDR; every other opcode SHALL go to ERROR.
REQ-021 ADD and AND: sr2mux_sel=ir5, aluop=alu_add or alu_and respectively, load_regfile=1, load_cc=1; next state FETCH1.
REQ-022 NOT: aluop=alu_not, load_regfile=1, load_cc=1; next state FETCH1.
REQ-023 BR: addr1mux_sel=0, addr2mux_sel=0, pcmux_sel=1, load_pc=branch_enable; next state FETCH1.
REQ-024 JMP: addr1mux_sel=1, addr2mux_sel=1, pcmux_sel=1, load_pc=1; next state FETCH1.
REQ-025 LEA: addr1mux_sel=0, addr2mux_sel=0, leamux_sel=1, regfilemux_sel=0, load_regfile=1, load_cc=1; next state FETCH1.
REQ-026 CALC_ADDR: alumux_sel=1, aluop=alu_add, marmux_sel=0, load_mar=1; next state LDR1 for LDR, STR1 for STR.
REQ-027 LDR1: mem_read=1, mdrmux_sel=1, load_mdr=mem_resp; the state SHALL remain LDR1 until mem_resp=1, then go to LDR2.
REQ-028 LDR2: regfilemux_sel=1, load_regfile=1, load_cc=1; next state FETCH1.
REQ-029 STR1: storemux_sel=1, aluop=alu_pass, mdrmux_sel=0, load_mdr=1; next state STR2.
REQ-030 STR2: mem_write=1, held until mem_resp=1; next state FETCH1.
REQ-031 Wait counter, width clog2(MEM_TIMEOUT+1): clears on entry to FETCH2, LDR1 or STR2, and increments on each cycle in those states with mem_resp=0.
REQ-032 On the MEM_TIMEOUT-th consecutive wait cycle, the next state SHALL be ERROR; if mem_resp=1 arrives on that same cycle, the response SHALL win and the FSM SHALL advance normally.
REQ-033 ERROR: error=1 with all strobes and requests 0; the FSM SHALL leave ERROR only through reset.

Reset
REQ-034 While rst_n=0, every output SHALL be 0, the state SHALL be FETCH1, and the wait counter and error SHALL be 0.
REQ-035 Assertion of rst_n mid-transaction SHALL drop mem_read and mem_write asynchronously, in the same cycle.
REQ-036 The first rising edge after rst_n goes high SHALL be evaluated in FETCH1.

Verification
REQ-037 Release reset -> first cycle: load_mar=1, marmux_sel=1, load_pc=1, all other loads 0.
REQ-038 ADD, ir5=1, mem_resp=1 on first FETCH2 cycle -> 5 cycles per instruction; in the ADD state sr2mux_sel=1, load_regfile=1, load_cc=1.
REQ-039 BR twice, branch_enable=0 then 1 -> load_pc=0 in the first BR state, then load_pc=1 with pcmux_sel=1 in the second.
REQ-040 STR with mem_resp delayed 3 cycles -> mem_write=1 and mem_byte_enable=2'b11 for exactly 4 cycles, then FETCH1.
REQ-041 MEM_TIMEOUT=4, mem_resp held 0 in FETCH2 -> error=1 after 4 wait cycles; mem_resp=1 on the 4th wait cycle instead -> FETCH3, error=0.
REQ-042 Opcode TRAP at DECODE -> ERROR, error=1 until rst_n pulses low, then FETCH1 with error=0.
